flappy_physics: RTL and testbench
=================================

# flappy_physics

Game-state and bird-motion engine for the FlappyBird design. It sits directly upstream of the VGA pixel renderer and supplies the bird's vertical position, the game state and the score. Its inputs are a per-frame tick, the debounced flap keypress pulse, and collision/pipe-pass flags from the pipe/renderer stage. The renderer and the seg7 score display consume its registered outputs.

## Interface
- Y_INIT, 240: bird row in IDLE and after reset.
- Y_MIN, 0: ceiling row.
- Y_MAX, 464: ground row (top of bird); reaching it kills the bird.
- GRAVITY, 1: velocity increment per frame (rows/frame²).
- FLAP_VEL, -8: velocity loaded on a flap (signed, rows/frame).
- VMAX, 10: maximum downward velocity.
- DEAD_FRAMES, 60: frames in DEAD before a flap is accepted.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per VGA frame.
- flap  in  1  one-cycle pulse per keypress, already edge-detected.
- collide  in  1  bird overlaps a pipe; level, sampled every cycle.
- pipe_pass  in  1  one-cycle pulse when the bird clears a pipe.
- state  out  2  0=IDLE, 1=FLYING, 2=DEAD; 3 is never produced.
- bird_y  out  9  bird top row, 0..Y_MAX.
- vel  out  6  signed velocity, two's complement.
- score  out  16  four BCD digits, {thousands,hundreds,tens,ones}.
- game_over  out  1  one-cycle pulse on entry to DEAD.

## Operation
- Reset (any cycle, any state): state=0, bird_y=Y_INIT, vel=0, score=16'h0000, game_over=0, dead frame counter=0. Reset overrides every other input in the same cycle.
- IDLE:
  - bird_y is held at Y_INIT and vel at 0.
  - A flap moves to FLYING, loads vel=FLAP_VEL and clears score to 0000.
  - frame_tick, collide and pipe_pass are ignored.
- FLYING, evaluated each cycle in this priority order:
  1. collide=1 → DEAD. bird_y and vel freeze. A pipe_pass in the same cycle is not counted.
  2. frame_tick=1 → motion update:
     - Compute y_next = bird_y + vel, with bird_y zero-extended and vel sign-extended to 11 bits (signed).
     - If y_next ≥ Y_MAX: bird_y=Y_MAX, vel=0, → DEAD.
     - Else if y_next ≤ Y_MIN: bird_y=Y_MIN, vel=0. This is not a death.
     - Otherwise bird_y=y_next[8:0] and vel=min(vel+GRAVITY, VMAX).
  3. flap=1 → vel=FLAP_VEL. This overrides the gravity/clamp velocity result of a simultaneous frame_tick. bird_y still moves by the old vel. A ground hit in the same cycle still kills.
  4. pipe_pass=1 → BCD score increment with per-digit carry (0009→0010, 0099→0100). Saturates at 9999.
- DEAD:
  - bird_y, vel and score are held.
  - Each frame_tick increments the dead counter, saturating at DEAD_FRAMES.
  - A flap with counter==DEAD_FRAMES → IDLE: bird_y=Y_INIT, vel=0, counter=0. score is held until the next start.
  - A flap with counter<DEAD_FRAMES is ignored.
- game_over is high for exactly the one cycle after the transition into DEAD. Both the collide path and the ground path produce it.

## Timing
- All outputs are registered; every input has 1-cycle latency to its effect on outputs.
- One motion update per frame_tick; frame_tick is never stretched or counted twice.
- score digits are always valid BCD (each nibble ≤ 9).

## Test plan
- Reset then hold idle:
  - After rst: state=0, bird_y=240, vel=0, score=0000, game_over=0.
  - 5 frame_ticks with no flap → all outputs unchanged.
- Start and fall:
  - flap in IDLE → state=1, vel=-8.
  - Then 3 frame_ticks → bird_y=232, 225, 219; vel=-7, -6, -5.
- Ground death:
  - Fall from 240 with no flaps until y_next ≥ 464 → bird_y=464, vel=0, state=2.
  - game_over high for exactly 1 cycle.
  - Further frame_ticks leave bird_y at 464.
- Simultaneous events:
  - flap with frame_tick at bird_y=300, vel=5 → bird_y=305, vel=-8.
  - collide with pipe_pass → state=2, score unchanged.
- Score:
  - 9 pipe_pass → 0009; 1 more → 0010.
  - Preload 9998 and pulse 3 times → 9999, stays 9999.
- Restart lockout and reset mid-flight:
  - In DEAD, flap after 59 ticks → ignored; flap after 60 ticks → state=0, bird_y=240, score kept.
  - rst while FLYING with bird_y=100 → all reset values next cycle.

Source files
------------

// File: rtl/flappy_physics.sv
// Bird motion, game state and BCD score engine for FlappyBird.
// All outputs are registered and each input takes effect one cycle after it is sampled.
module flappy_physics #(
    parameter int Y_INIT      = 240,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 464,
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = -8,
    parameter int VMAX        = 10,
    parameter int DEAD_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        flap,
    input  logic        collide,
    input  logic        pipe_pass,
    output logic [1:0]  state,
    output logic [8:0]  bird_y,
    output logic [5:0]  vel,
    output logic [15:0] score,
    output logic        game_over
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [8:0]         Y_INIT_V  = 9'(Y_INIT);
    localparam logic [8:0]         Y_MAX_V   = 9'(Y_MAX);
    localparam logic [8:0]         Y_MIN_V   = 9'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S   = 11'(Y_MAX);
    localparam logic signed [10:0] Y_MIN_S   = 11'(Y_MIN);
    localparam logic signed [5:0]  VMAX_S    = 6'(VMAX);
    localparam logic signed [5:0]  GRAV_S    = 6'(GRAVITY);
    localparam logic [5:0]         FLAP_V    = 6'(FLAP_VEL);
    localparam logic [5:0]         DEAD_CNT  = 6'(DEAD_FRAMES);

    state_t      state_q, state_d;
    logic [8:0]  y_d;
    logic [5:0]  vel_d;
    logic [15:0] score_d;
    logic        go_d;
    logic [5:0]  cnt_q, cnt_d;

    logic signed [10:0] y_ext, v_ext, y_next;
    logic signed [5:0]  vel_s, vel_grav;
    logic               ground_hit;

    // BCD increment with per-digit carry, saturating at 9999
    function automatic logic [15:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        carry;
        r     = s;
        carry = 1'b1;
        if (s != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] >= 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign y_ext      = {2'b00, bird_y};
    assign v_ext      = {{5{vel[5]}}, vel};
    assign y_next     = y_ext + v_ext;
    assign vel_s      = vel;
    assign vel_grav   = (vel_s > VMAX_S - GRAV_S) ? VMAX_S : vel_s + GRAV_S;
    assign ground_hit = (y_next >= Y_MAX_S);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bird_y    <= Y_INIT_V;
            vel       <= 6'd0;
            score     <= 16'h0000;
            game_over <= 1'b0;
            cnt_q     <= 6'd0;
        end else begin
            state_q   <= state_d;
            bird_y    <= y_d;
            vel       <= vel_d;
            score     <= score_d;
            game_over <= go_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = bird_y;
        vel_d   = vel;
        score_d = score;
        go_d    = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                y_d   = Y_INIT_V;
                vel_d = 6'd0;
                if (flap) begin
                    state_d = FLYING;
                    vel_d   = FLAP_V;
                    score_d = 16'h0000;
                    cnt_d   = 6'd0;
                end
            end

            FLYING: begin
                if (collide) begin
                    state_d = DEAD;
                    go_d    = 1'b1;
                end else begin
                    if (frame_tick) begin
                        if (ground_hit) begin
                            y_d     = Y_MAX_V;
                            vel_d   = 6'd0;
                            state_d = DEAD;
                            go_d    = 1'b1;
                        end else if (y_next <= Y_MIN_S) begin
                            y_d   = Y_MIN_V;
                            vel_d = 6'd0;
                        end else begin
                            y_d   = y_next[8:0];
                            vel_d = vel_grav;
                        end
                    end
                    // A ground death keeps vel at zero even if a flap lands on the same cycle
                    if (flap && !(frame_tick && ground_hit)) begin
                        vel_d = FLAP_V;
                    end
                    if (pipe_pass) begin
                        score_d = bcd_inc(score);
                    end
                end
            end

            DEAD: begin
                if (frame_tick && (cnt_q < DEAD_CNT)) begin
                    cnt_d = cnt_q + 6'd1;
                end
                if (flap && (cnt_q == DEAD_CNT)) begin
                    state_d = IDLE;
                    y_d     = Y_INIT_V;
                    vel_d   = 6'd0;
                    cnt_d   = 6'd0;
                end
            end

            default: begin
                state_d = IDLE;
                y_d     = Y_INIT_V;
                vel_d   = 6'd0;
                cnt_d   = 6'd0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_flappy_physics.sv
// Scoreboard bench for flappy_physics: stimulus queues expected outputs, a negedge monitor checks them.
module tb_flappy_physics;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        flap = 1'b0;
    logic        collide = 1'b0;
    logic        pipe_pass = 1'b0;
    logic [1:0]  state;
    logic [8:0]  bird_y;
    logic [5:0]  vel;
    logic [15:0] score;
    logic        game_over;

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic [8:0]  y;
        logic [5:0]  v;
        logic [15:0] sc;
        logic        go;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Bench-side motion model state for long flight segments
    int          my, mv;
    logic [1:0]  mst;
    logic [15:0] msc;

    flappy_physics dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .flap(flap),
        .collide(collide), .pipe_pass(pipe_pass), .state(state),
        .bird_y(bird_y), .vel(vel), .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mk(input string nm, input logic [1:0] st, input int y,
                                input int v, input logic [15:0] sc, input logic go);
        exp_t e;
        e.name = nm;
        e.st   = st;
        e.y    = 9'(y);
        e.v    = 6'(v);
        e.sc   = sc;
        e.go   = go;
        return e;
    endfunction

    task automatic check_field(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic check_output(input exp_t e);
        check_field({e.name, ".state"}, int'(state), int'(e.st));
        check_field({e.name, ".bird_y"}, int'(bird_y), int'(e.y));
        check_field({e.name, ".vel"}, int'($signed(vel)), int'($signed(e.v)));
        check_field({e.name, ".score"}, int'(score), int'(e.sc));
        check_field({e.name, ".game_over"}, int'(game_over), int'(e.go));
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) check_output(sb.pop_front());
    end

    task automatic apply_stimulus(input bit r, input bit ft, input bit fl, input bit co,
                                  input bit pp, input bit chk, input exp_t e);
        rst        = r;
        frame_tick = ft;
        flap       = fl;
        collide    = co;
        pipe_pass  = pp;
        @(posedge clk);
        if (chk) sb.push_back(e);
        @(negedge clk);
        rst        = 1'b0;
        frame_tick = 1'b0;
        flap       = 1'b0;
        collide    = 1'b0;
        pipe_pass  = 1'b0;
    endtask

    task automatic fly_ticks(input int n, input string nm);
        int yn;
        for (int i = 0; i < n; i++) begin
            yn = my + mv;
            if (yn >= 464) begin
                my = 464; mv = 0; mst = 2'd2;
            end else if (yn <= 0) begin
                my = 0; mv = 0;
            end else begin
                my = yn;
                mv = (mv + 1 > 10) ? 10 : mv + 1;
            end
            apply_stimulus(0, 1, 0, 0, 0, 1, mk(nm, mst, my, mv, msc, mst == 2'd2));
            if (mst == 2'd2) break;
        end
    endtask

    task automatic flap_only(input string nm);
        mv = -8;
        apply_stimulus(0, 0, 1, 0, 0, 1, mk(nm, 2'd1, my, mv, msc, 1'b0));
    endtask

    initial begin
        // Reset wins over simultaneous inputs
        apply_stimulus(1, 1, 1, 0, 1, 1, mk("reset", 0, 240, 0, 16'h0000, 0));
        for (int i = 0; i < 5; i++)
            apply_stimulus(0, 1, 0, 1, 1, 1, mk("idle_tick", 0, 240, 0, 16'h0000, 0));

        apply_stimulus(0, 0, 1, 0, 0, 1, mk("start", 1, 240, -8, 16'h0000, 0));
        apply_stimulus(0, 1, 0, 0, 0, 1, mk("fall1", 1, 232, -7, 16'h0000, 0));
        apply_stimulus(0, 1, 0, 0, 0, 1, mk("fall2", 1, 225, -6, 16'h0000, 0));
        apply_stimulus(0, 1, 0, 0, 0, 1, mk("fall3", 1, 219, -5, 16'h0000, 0));
        for (int i = 1; i <= 3; i++)
            apply_stimulus(0, 0, 0, 0, 1, 1, mk("pass3", 1, 219, -5, 16'(i), 0));

        // Free fall to the ground
        my = 219; mv = -5; mst = 2'd1; msc = 16'h0003;
        fly_ticks(200, "ground");
        if (mst != 2'd2) check_field("ground_reached", 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1, mk("go_drop", 2, 464, 0, 16'h0003, 0));
        apply_stimulus(0, 1, 0, 0, 0, 1, mk("dead_tick", 2, 464, 0, 16'h0003, 0));

        // Restart lockout: 59 ticks so far after this loop
        for (int i = 0; i < 58; i++)
            apply_stimulus(0, 1, 0, 0, 0, 0, mk("", 0, 0, 0, 0, 0));
        apply_stimulus(0, 0, 1, 0, 0, 1, mk("flap59", 2, 464, 0, 16'h0003, 0));
        apply_stimulus(0, 1, 0, 0, 0, 1, mk("tick60", 2, 464, 0, 16'h0003, 0));
        apply_stimulus(0, 0, 1, 0, 0, 1, mk("flap60", 0, 240, 0, 16'h0003, 0));

        apply_stimulus(0, 0, 1, 0, 0, 1, mk("restart", 1, 240, -8, 16'h0000, 0));
        for (int i = 1; i <= 9; i++)
            apply_stimulus(0, 0, 0, 0, 1, 1, mk("score_ones", 1, 240, -8, 16'(i), 0));
        apply_stimulus(0, 0, 0, 0, 1, 1, mk("score_10", 1, 240, -8, 16'h0010, 0));

        // Steer the bird to y=300, vel=5 via offsets +49,+49,+9,-21,-26
        my = 240; mv = -8; mst = 2'd1; msc = 16'h0010;
        fly_ticks(22, "seg1"); flap_only("seg1_flap");
        fly_ticks(22, "seg2"); flap_only("seg2_flap");
        fly_ticks(18, "seg3"); flap_only("seg3_flap");
        fly_ticks(3,  "seg4"); flap_only("seg4_flap");
        fly_ticks(13, "seg5");
        apply_stimulus(0, 1, 1, 0, 0, 1, mk("flap_tick", 1, 305, -8, 16'h0010, 0));

        apply_stimulus(0, 1, 0, 1, 1, 1, mk("collide_pass", 2, 305, -8, 16'h0010, 1));
        apply_stimulus(0, 0, 0, 0, 0, 1, mk("collide_after", 2, 305, -8, 16'h0010, 0));

        for (int i = 0; i < 60; i++)
            apply_stimulus(0, 1, 0, 0, 0, 0, mk("", 0, 0, 0, 0, 0));
        apply_stimulus(0, 0, 1, 0, 0, 1, mk("to_idle", 0, 240, 0, 16'h0010, 0));
        apply_stimulus(0, 0, 1, 0, 0, 1, mk("start2", 1, 240, -8, 16'h0000, 0));

        // Long run of pipe passes up to saturation
        for (int i = 1; i <= 9998; i++) begin
            bit   chk;
            logic [15:0] want;
            chk  = 1'b1;
            case (i)
                99:      want = 16'h0099;
                100:     want = 16'h0100;
                999:     want = 16'h0999;
                1000:    want = 16'h1000;
                9998:    want = 16'h9998;
                default: begin want = 16'h0000; chk = 1'b0; end
            endcase
            apply_stimulus(0, 0, 0, 0, 1, chk, mk("score_bcd", 1, 240, -8, want, 0));
        end
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 0, 0, 0, 1, 1, mk("score_sat", 1, 240, -8, 16'h9999, 0));

        // Climb to y=100 with four -35 segments, then reset mid-flight
        my = 240; mv = -8; mst = 2'd1; msc = 16'h9999;
        fly_ticks(7, "climb1"); flap_only("climb1_flap");
        fly_ticks(7, "climb2"); flap_only("climb2_flap");
        fly_ticks(7, "climb3"); flap_only("climb3_flap");
        fly_ticks(7, "climb4");
        apply_stimulus(0, 0, 0, 0, 0, 1, mk("at_100", 1, 100, -1, 16'h9999, 0));
        apply_stimulus(1, 1, 1, 0, 1, 1, mk("rst_flying", 0, 240, 0, 16'h0000, 0));

        repeat (3) @(negedge clk);
        check_field("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
